// File: rtl/apb_sram_pkg.sv
// -----------------------------------------------------------------------------
// apb_sram_pkg
// Shared definitions for the APB SRAM slave:
//   - FSM state encoding (ST_IDLE, ST_ACCESS)
//   - clog2 and the byte-lane derivations used to size strobes and address slices
//   - legal-range limits for DATA_WIDTH and WAIT_STATES
// -----------------------------------------------------------------------------
package apb_sram_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   // Wait-state counter width covers the full legal WAIT_STATES range.
   localparam int CNT_W           = 2;
   localparam int MIN_WAIT_STATES = 0;
   localparam int MAX_WAIT_STATES = 3;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int x = value - 1; x > 0; x = x >> 1) r++;
      return r;
   endfunction

   // Number of byte lanes in a data word.
   function automatic int lane_count(input int data_width);
      return data_width / 8;
   endfunction

   // BL: number of paddr bits that select a byte within a word.
   function automatic int byte_lane_bits(input int data_width);
      return clog2(data_width / 8);
   endfunction

   function automatic bit data_width_legal(input int data_width);
      return (data_width == 8) || (data_width == 16) ||
             (data_width == 32) || (data_width == 64);
   endfunction

endpackage

// File: rtl/apb_sram_if.sv
// -----------------------------------------------------------------------------
// apb_sram_if
// APB4 bus bundle between a master and the apb_sram slave.
//   master: drives psel/penable/pwrite/paddr/pwdata/pstrb, receives the response
//   slave : receives the request, drives prdata/pready/pslverr
// -----------------------------------------------------------------------------
interface apb_sram_if #(
   parameter int PADDR_WIDTH = 12,
   parameter int DATA_WIDTH  = 32
);
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [PADDR_WIDTH-1:0]  paddr;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pready;
   logic                    pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/sram_be_core.sv
// -----------------------------------------------------------------------------
// sram_be_core
// Synchronous single-port RAM with per-byte write enables and a registered
// read port. No reset and no bus protocol knowledge.
//   clk   : rising-edge clock
//   we    : write enable, qualified per lane by be
//   be    : byte-lane enables
//   re    : read enable; rdata loads mem[addr] and holds otherwise
//   addr  : word address shared by read and write
//   wdata : write data
//   rdata : registered read data
// -----------------------------------------------------------------------------
import apb_sram_pkg::*;

module sram_be_core #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);
   localparam int LANES = lane_count(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // NOTE: the array and its read register are left unreset so they map onto
   // RAM macros; contents deliberately survive rst_n.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/apb_sram.sv
// -----------------------------------------------------------------------------
// apb_sram
// APB4 slave in front of a byte-writable single-port SRAM, with programmable
// wait states and PSLVERR on misaligned or out-of-range addresses.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : apb_sram_if slave modport (psel, penable, pwrite, paddr, pwdata,
//           pstrb in; prdata, pready, pslverr out)
// -----------------------------------------------------------------------------
import apb_sram_pkg::*;

module apb_sram #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 6,
   parameter int PADDR_WIDTH = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   apb_sram_if.slave bus
);
   localparam int BL     = byte_lane_bits(DATA_WIDTH);
   localparam int IDX_HI = ADDR_WIDTH + BL;
   localparam logic [PADDR_WIDTH-1:0] LANE_MASK = PADDR_WIDTH'((1 << BL) - 1);

   if (!data_width_legal(DATA_WIDTH)) begin : g_bad_data_width
      $error("apb_sram: DATA_WIDTH must be 8, 16, 32 or 64");
   end
   if (WAIT_STATES < MIN_WAIT_STATES || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait
      $error("apb_sram: WAIT_STATES out of range");
   end
   if (PADDR_WIDTH < IDX_HI) begin : g_bad_paddr
      $error("apb_sram: PADDR_WIDTH too narrow for ADDR_WIDTH and DATA_WIDTH");
   end

   state_t                state_q, state_nxt;
   logic [CNT_W-1:0]      cnt_q, cnt_nxt;
   logic                  err_q, err_nxt;
   logic                  wr_q, wr_nxt;
   logic                  zero_q, zero_nxt;   // forces prdata to 0 (reset / error read)
   logic [ADDR_WIDTH-1:0] idx_q, idx_nxt;

   logic                  setup_err;
   logic [ADDR_WIDTH-1:0] paddr_idx;
   logic                  complete;
   logic                  mem_we, mem_re;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Decode of the setup-phase address: misaligned byte offset or any bit set
   // above the word index is an error.
   assign setup_err = (|(bus.paddr & LANE_MASK)) || ((bus.paddr >> IDX_HI) != '0);
   assign paddr_idx = bus.paddr[IDX_HI-1:BL];

   assign complete    = (state_q == ST_ACCESS) && (cnt_q == '0) && bus.psel && bus.penable;
   assign bus.pready  = complete;
   assign bus.pslverr = complete && err_q;

   // Reads only launch in IDLE and writes only commit in ACCESS, so the single
   // port never sees both in the same cycle.
   assign mem_we   = complete && wr_q && !err_q;
   assign mem_re   = (state_q == ST_IDLE) && bus.psel && !bus.pwrite && !setup_err;
   assign mem_addr = (state_q == ST_ACCESS) ? idx_q : paddr_idx;

   assign bus.prdata = zero_q ? '0 : mem_rdata;

   sram_be_core #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_core (
      .clk  (clk),
      .we   (mem_we),
      .be   (bus.pstrb),
      .re   (mem_re),
      .addr (mem_addr),
      .wdata(bus.pwdata),
      .rdata(mem_rdata)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         zero_q  <= 1'b1;
         idx_q   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         err_q   <= err_nxt;
         wr_q    <= wr_nxt;
         zero_q  <= zero_nxt;
         idx_q   <= idx_nxt;
      end
   end

   // NOTE: every output of this block is given its hold value first, so no
   // path through the case statement can infer a latch.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      err_nxt   = err_q;
      wr_nxt    = wr_q;
      zero_nxt  = zero_q;
      idx_nxt   = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.psel) begin
               state_nxt = ST_ACCESS;
               cnt_nxt   = CNT_W'(WAIT_STATES);
               err_nxt   = setup_err;
               wr_nxt    = bus.pwrite;
               idx_nxt   = paddr_idx;
               // A read refreshes prdata: real data if legal, zero if not.
               if (!bus.pwrite) zero_nxt = setup_err;
            end
         end
         ST_ACCESS: begin
            if (!bus.psel) begin
               state_nxt = ST_IDLE;           // aborted transfer
            end else if (bus.penable) begin
               if (cnt_q != '0) cnt_nxt   = cnt_q - 1'b1;
               else             state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_apb_sram.sv
// -----------------------------------------------------------------------------
// tb_apb_sram
// Directed bench for apb_sram. Three instances (WAIT_STATES = 0, 1, 3) share
// the request signals; each has its own psel so only one is addressed at once.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
import apb_sram_pkg::*;

module tb_apb_sram;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  psel_v = '0;    // [0]: WS=0, [1]: WS=1, [2]: WS=3
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [11:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   apb_sram_if #(.PADDR_WIDTH(12), .DATA_WIDTH(32)) bus_ws0 ();
   apb_sram_if #(.PADDR_WIDTH(12), .DATA_WIDTH(32)) bus_ws1 ();
   apb_sram_if #(.PADDR_WIDTH(12), .DATA_WIDTH(32)) bus_ws3 ();

   assign bus_ws0.psel = psel_v[0];
   assign bus_ws1.psel = psel_v[1];
   assign bus_ws3.psel = psel_v[2];
   assign bus_ws0.penable = penable;
   assign bus_ws1.penable = penable;
   assign bus_ws3.penable = penable;
   assign bus_ws0.pwrite = pwrite;
   assign bus_ws1.pwrite = pwrite;
   assign bus_ws3.pwrite = pwrite;
   assign bus_ws0.paddr = paddr;
   assign bus_ws1.paddr = paddr;
   assign bus_ws3.paddr = paddr;
   assign bus_ws0.pwdata = pwdata;
   assign bus_ws1.pwdata = pwdata;
   assign bus_ws3.pwdata = pwdata;
   assign bus_ws0.pstrb = pstrb;
   assign bus_ws1.pstrb = pstrb;
   assign bus_ws3.pstrb = pstrb;

   apb_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .PADDR_WIDTH(12), .WAIT_STATES(0))
      dut_ws0 (.clk(clk), .rst_n(rst_n), .bus(bus_ws0));
   apb_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .PADDR_WIDTH(12), .WAIT_STATES(1))
      dut_ws1 (.clk(clk), .rst_n(rst_n), .bus(bus_ws1));
   apb_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .PADDR_WIDTH(12), .WAIT_STATES(3))
      dut_ws3 (.clk(clk), .rst_n(rst_n), .bus(bus_ws3));

   function automatic logic get_ready(input int d);
      case (d)
         0:       return bus_ws0.pready;
         1:       return bus_ws1.pready;
         default: return bus_ws3.pready;
      endcase
   endfunction

   function automatic logic get_err(input int d);
      case (d)
         0:       return bus_ws0.pslverr;
         1:       return bus_ws1.pslverr;
         default: return bus_ws3.pslverr;
      endcase
   endfunction

   function automatic logic [31:0] get_rdata(input int d);
      case (d)
         0:       return bus_ws0.prdata;
         1:       return bus_ws1.prdata;
         default: return bus_ws3.prdata;
      endcase
   endfunction

   // One APB transfer to instance d. Entered 1ns after a rising edge (setup
   // driven immediately), left 1ns after the completing edge with psel low,
   // so consecutive calls are back-to-back. ncyc = cycle on which pready was
   // seen (setup = 1). paddr is scrambled during ACCESS to confirm the slave
   // latched it in setup.
   task automatic xfer(input int d, input logic wr, input logic [11:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd, output logic err, output int ncyc);
      psel_v = '0;
      psel_v[d] = 1'b1;
      penable = 1'b0;
      pwrite = wr;
      paddr = a;
      pwdata = wd;
      pstrb = st;
      ncyc = 1;
      err = 1'b0;
      @(posedge clk);
      #1;
      penable = 1'b1;
      paddr = a ^ 12'h040;
      ncyc = 2;
      while (1) begin
         @(negedge clk);
         if (get_ready(d)) break;
         if (ncyc >= 12) begin
            errors++;
            checks++;
            $display("FAIL xfer_timeout: pready never rose (dut %0d addr %h)", d, a);
            break;
         end
         @(posedge clk);
         #1;
         ncyc++;
      end
      err = get_err(d);
      @(posedge clk);
      #1;
      psel_v = '0;
      penable = 1'b0;
      rd = get_rdata(d);
   endtask

   task automatic test_reset();
      #2;
      if (dut_ws1.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut_ws1.state_q, ST_IDLE); end
      checks++;
      if (dut_ws1.cnt_q !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", dut_ws1.cnt_q); end
      checks++;
      if (dut_ws1.err_q !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", dut_ws1.err_q); end
      checks++;
      if (bus_ws1.prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h want 0", bus_ws1.prdata); end
      checks++;
      if (bus_ws1.pready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b want 0", bus_ws1.pready); end
      checks++;
      if (bus_ws1.pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b want 0", bus_ws1.pslverr); end
      checks++;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      logic [31:0] rd;
      logic        er;
      int          n;
      xfer(1, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd, er, n);
      if (n !== 3) begin errors++; $display("FAIL basic_wr_cycles: got %0d want 3", n); end
      checks++;
      if (er !== 1'b0) begin errors++; $display("FAIL basic_wr_err: got %b want 0", er); end
      checks++;
      xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, n);
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h want DEADBEEF", rd); end
      checks++;
      if (n !== 3) begin errors++; $display("FAIL basic_rd_cycles: got %0d want 3", n); end
      checks++;
      if (er !== 1'b0) begin errors++; $display("FAIL basic_rd_err: got %b want 0", er); end
      checks++;
      // A write elsewhere must leave prdata holding the last read.
      xfer(1, 1'b1, 12'h014, 32'h01020304, 4'hF, rd, er, n);
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_prdata_hold: got %h want DEADBEEF", rd); end
      checks++;
   endtask

   task automatic test_strobes();
      logic [31:0] rd;
      logic        er;
      int          n;
      xfer(1, 1'b1, 12'h020, 32'h11223344, 4'hF, rd, er, n);
      xfer(1, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5, rd, er, n);
      xfer(1, 1'b0, 12'h020, 32'h0, 4'h0, rd, er, n);
      if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge: got %h want 11BB33DD", rd); end
      checks++;
      xfer(1, 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, rd, er, n);
      if (er !== 1'b0) begin errors++; $display("FAIL strobe_zero_err: got %b want 0", er); end
      checks++;
      xfer(1, 1'b0, 12'h020, 32'h0, 4'h0, rd, er, n);
      if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_zero_data: got %h want 11BB33DD", rd); end
      checks++;
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic        er;
      int          n;
      xfer(1, 1'b1, 12'h000, 32'h0A0B0C0D, 4'hF, rd, er, n);
      xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, n);     // prdata now nonzero
      xfer(1, 1'b0, 12'h013, 32'h0, 4'h0, rd, er, n);
      if (er !== 1'b1) begin errors++; $display("FAIL err_misaligned_rd_flag: got %b want 1", er); end
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL err_misaligned_rd_data: got %h want 0", rd); end
      checks++;
      if (n !== 3) begin errors++; $display("FAIL err_misaligned_rd_cycles: got %0d want 3", n); end
      checks++;
      xfer(1, 1'b1, 12'h100, 32'hFFFFFFFF, 4'hF, rd, er, n);
      if (er !== 1'b1) begin errors++; $display("FAIL err_range_wr_flag: got %b want 1", er); end
      checks++;
      xfer(1, 1'b1, 12'h011, 32'hFFFFFFFF, 4'hF, rd, er, n);
      if (er !== 1'b1) begin errors++; $display("FAIL err_misaligned_wr_flag: got %b want 1", er); end
      checks++;
      xfer(1, 1'b0, 12'h000, 32'h0, 4'h0, rd, er, n);
      if (rd !== 32'h0A0B0C0D) begin errors++; $display("FAIL err_mem000_kept: got %h want 0A0B0C0D", rd); end
      checks++;
      if (er !== 1'b0) begin errors++; $display("FAIL err_legal_rd_flag: got %b want 0", er); end
      checks++;
      xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, n);
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL err_mem010_kept: got %h want DEADBEEF", rd); end
      checks++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic        er;
      int          nw;
      int          nr;
      int          d;
      int          ws;
      logic [31:0] val;
      for (int k = 0; k < 2; k++) begin
         d   = (k == 0) ? 0 : 2;
         ws  = (k == 0) ? 0 : 3;
         val = (k == 0) ? 32'hCAFEF00D : 32'h5A5AA5A5;
         xfer(d, 1'b1, 12'h0FC, val, 4'hF, rd, er, nw);
         xfer(d, 1'b0, 12'h0FC, 32'h0, 4'h0, rd, er, nr);
         if (nw !== 2 + ws) begin errors++; $display("FAIL b2b_ws%0d_wr_cycles: got %0d want %0d", ws, nw, 2 + ws); end
         checks++;
         if (nr !== 2 + ws) begin errors++; $display("FAIL b2b_ws%0d_rd_cycles: got %0d want %0d", ws, nr, 2 + ws); end
         checks++;
         if (rd !== val) begin errors++; $display("FAIL b2b_ws%0d_rd_data: got %h want %h", ws, rd, val); end
         checks++;
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic        er;
      int          n;
      xfer(1, 1'b1, 12'h008, 32'h0BADF00D, 4'hF, rd, er, n);
      xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, rd, er, n);
      // Start a write, then reset during its wait cycle.
      psel_v = 3'b010;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = 12'h008;
      pwdata = 32'h12345678;
      pstrb = 4'hF;
      @(posedge clk);
      #1 penable = 1'b1;
      @(negedge clk);
      if (bus_ws1.pready !== 1'b0) begin errors++; $display("FAIL rstmid_wait_pready: got %b want 0", bus_ws1.pready); end
      checks++;
      #2 rst_n = 1'b0;
      #1;
      if (bus_ws1.pready !== 1'b0) begin errors++; $display("FAIL rstmid_pready: got %b want 0", bus_ws1.pready); end
      checks++;
      if (bus_ws1.prdata !== 32'h0) begin errors++; $display("FAIL rstmid_prdata: got %h want 0", bus_ws1.prdata); end
      checks++;
      if (dut_ws1.state_q !== ST_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d want %0d", dut_ws1.state_q, ST_IDLE); end
      checks++;
      psel_v = '0;
      penable = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, rd, er, n);
      if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL rstmid_mem_kept: got %h want 0BADF00D", rd); end
      checks++;
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      logic        er;
      int          n;
      psel_v = 3'b010;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = 12'h010;
      pwdata = 32'h55555555;
      pstrb = 4'hF;
      @(posedge clk);
      #1 penable = 1'b1;
      @(negedge clk);
      if (bus_ws1.pready !== 1'b0) begin errors++; $display("FAIL abort_wait_pready: got %b want 0", bus_ws1.pready); end
      checks++;
      @(posedge clk);
      #1;
      psel_v = '0;
      penable = 1'b0;
      @(negedge clk);
      if (bus_ws1.pready !== 1'b0) begin errors++; $display("FAIL abort_pready: got %b want 0", bus_ws1.pready); end
      checks++;
      @(posedge clk);
      #1;
      xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, n);
      if (n !== 3) begin errors++; $display("FAIL abort_next_cycles: got %0d want 3", n); end
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL abort_mem_kept: got %h want DEADBEEF", rd); end
      checks++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_strobes();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end
endmodule
